// File: rtl/spmv_stream_feeder.sv
// spmv_stream_feeder: producer side of the SpMV channel FIFOs.
// Walks nnz COO entries (value,row,col), fetches vec[col], and pushes
// matrix_val / vec_val / row_id into three FIFOs on the same cycle.
// Optional macro FEEDER_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module spmv_stream_feeder #(
  parameter int MAT_W  = 32,
  parameter int VEC_W  = 32,
  parameter int ROW_W  = 16,
  parameter int COL_W  = 16,
  parameter int NNZ_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NNZ_AW-1:0] nnz,
  output logic              busy,
  output logic              done,
  output logic              ent_rd_en,
  output logic [NNZ_AW-1:0] ent_addr,
  input  logic [MAT_W-1:0]  ent_val,
  input  logic [ROW_W-1:0]  ent_row,
  input  logic [COL_W-1:0]  ent_col,
  output logic              vec_rd_en,
  output logic [COL_W-1:0]  vec_addr,
  input  logic [VEC_W-1:0]  vec_rdata,
  output logic              matrix_val_wr_en,
  output logic [MAT_W-1:0]  matrix_val_din,
  input  logic              matrix_val_full,
  output logic              vec_val_wr_en,
  output logic [VEC_W-1:0]  vec_val_din,
  input  logic              vec_val_full,
  output logic              row_id_wr_en,
  output logic [ROW_W-1:0]  row_id_din,
  input  logic              row_id_full
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ENT,
    WAIT_ENT,
    WAIT_VEC,
    PUSH,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NNZ_AW-1:0] idx_q, idx_d;
  logic [NNZ_AW-1:0] nnz_q, nnz_d;
  logic [MAT_W-1:0]  val_q;
  logic [ROW_W-1:0]  row_q;
  logic [VEC_W-1:0]  vec_q;
  logic              fifo_ok;

  assign fifo_ok = !(matrix_val_full || vec_val_full || row_id_full);

  // State, index and latched entry count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nnz_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nnz_q   <= nnz_d;
    end
  end

  // Capture entry fields after the entry read and vector data after the vector read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      row_q <= '0;
      vec_q <= '0;
    end else begin
      if (state_q == WAIT_ENT) begin
        val_q <= ent_val;
        row_q <= ent_row;
      end
      if (state_q == WAIT_VEC) begin
        vec_q <= vec_rdata;
      end
    end
  end

  // Next-state logic and all strobes; FIFO writes gated by all three full flags.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    nnz_d            = nnz_q;
    ent_rd_en        = 1'b0;
    ent_addr         = '0;
    vec_rd_en        = 1'b0;
    vec_addr         = '0;
    matrix_val_wr_en = 1'b0;
    vec_val_wr_en    = 1'b0;
    row_id_wr_en     = 1'b0;
    done             = 1'b0;
    busy             = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nnz != '0) begin
            nnz_d   = nnz;
            idx_d   = '0;
            state_d = RD_ENT;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ENT: begin
        busy      = 1'b1;
        ent_rd_en = 1'b1;
        ent_addr  = idx_q;
        state_d   = WAIT_ENT;
      end
      WAIT_ENT: begin
        busy      = 1'b1;
        vec_rd_en = 1'b1;
        vec_addr  = ent_col;
        state_d   = WAIT_VEC;
      end
      WAIT_VEC: begin
        busy    = 1'b1;
        state_d = PUSH;
      end
      PUSH: begin
        busy = 1'b1;
        if (fifo_ok) begin
          matrix_val_wr_en = 1'b1;
          vec_val_wr_en    = 1'b1;
          row_id_wr_en     = 1'b1;
          if (idx_q == nnz_q - NNZ_AW'(1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + NNZ_AW'(1);
            state_d = RD_ENT;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign matrix_val_din = val_q;
  assign vec_val_din    = vec_q;
  assign row_id_din     = row_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count PUSH cycles blocked by any full FIFO; saturating, cleared by a start in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_cnt_q <= '0;
    end else if (state_q == PUSH && !fifo_ok && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_spmv_stream_feeder.sv
// Directed self-checking bench for spmv_stream_feeder with RAM and FIFO-side models.
module tb_spmv_stream_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] nnz = '0;
  logic        busy, done, ent_rd_en, vec_rd_en;
  logic [15:0] ent_addr, vec_addr;
  logic [31:0] ent_val;
  logic [15:0] ent_row, ent_col;
  logic [31:0] vec_rdata;
  logic        matrix_val_wr_en, vec_val_wr_en, row_id_wr_en;
  logic [31:0] matrix_val_din, vec_val_din;
  logic [15:0] row_id_din;
  logic        matrix_val_full = 1'b0;
  logic        vec_val_full = 1'b0;
  logic        row_id_full = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  spmv_stream_feeder #(
    .MAT_W (32),
    .VEC_W (32),
    .ROW_W (16),
    .COL_W (16),
    .NNZ_AW(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .nnz             (nnz),
    .busy            (busy),
    .done            (done),
    .ent_rd_en       (ent_rd_en),
    .ent_addr        (ent_addr),
    .ent_val         (ent_val),
    .ent_row         (ent_row),
    .ent_col         (ent_col),
    .vec_rd_en       (vec_rd_en),
    .vec_addr        (vec_addr),
    .vec_rdata       (vec_rdata),
    .matrix_val_wr_en(matrix_val_wr_en),
    .matrix_val_din  (matrix_val_din),
    .matrix_val_full (matrix_val_full),
    .vec_val_wr_en   (vec_val_wr_en),
    .vec_val_din     (vec_val_din),
    .vec_val_full    (vec_val_full),
    .row_id_wr_en    (row_id_wr_en),
    .row_id_din      (row_id_din),
    .row_id_full     (row_id_full)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Host-loaded RAM models: one-cycle read latency.
  logic [31:0] m_val [0:65535];
  logic [15:0] m_row [0:65535];
  logic [15:0] m_col [0:65535];
  logic [31:0] m_vec [0:65535];

  always @(posedge clk) begin
    if (ent_rd_en) begin
      ent_val <= m_val[ent_addr];
      ent_row <= m_row[ent_addr];
      ent_col <= m_col[ent_addr];
    end
    if (vec_rd_en) vec_rdata <= m_vec[vec_addr];
  end

  // FIFO-side monitor: logs every write and event with the cycle it occurred in.
  int unsigned cyc = 0;
  int unsigned n_rd = 0;
  int unsigned n_busy = 0;
  logic [31:0] m_log[$];
  logic [31:0] v_log[$];
  logic [15:0] r_log[$];
  int unsigned w_cyc[$];
  int unsigned d_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (matrix_val_wr_en) begin
      m_log.push_back(matrix_val_din);
      w_cyc.push_back(cyc);
    end
    if (vec_val_wr_en) v_log.push_back(vec_val_din);
    if (row_id_wr_en)  r_log.push_back(row_id_din);
    if (done)          d_cyc.push_back(cyc);
    if (ent_rd_en)     n_rd++;
    if (busy)          n_busy++;
  end

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned s0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    m_log.delete();
    v_log.delete();
    r_log.delete();
    w_cyc.delete();
    d_cyc.delete();
    n_rd = 0;
    n_busy = 0;
  endtask

  task automatic go(input logic [15:0] n);
    start = 1'b1;
    nnz   = n;
    s0    = cyc;
    tick();
    start = 1'b0;
    nnz   = 16'hFFFF;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ent_rd"}, ent_rd_en, 0);
    chk({tag, "_ent_addr"}, ent_addr, 0);
    chk({tag, "_vec_rd"}, vec_rd_en, 0);
    chk({tag, "_vec_addr"}, vec_addr, 0);
    chk({tag, "_wr"}, {matrix_val_wr_en, vec_val_wr_en, row_id_wr_en}, 0);
    chk({tag, "_din"}, {matrix_val_din, vec_val_din, row_id_din}, 0);
  endtask

  task automatic chk_three(input string tag, input int unsigned base);
    chk({tag, "_nw"}, m_log.size(), 3);
    chk({tag, "_nv"}, v_log.size(), 3);
    chk({tag, "_nr"}, r_log.size(), 3);
    if (m_log.size() == 3 && v_log.size() == 3 && r_log.size() == 3 && w_cyc.size() == 3) begin
      chk({tag, "_e0"}, {m_log[0], v_log[0], r_log[0]}, {32'd5, 32'd30, 16'd0});
      chk({tag, "_e1"}, {m_log[1], v_log[1], r_log[1]}, {32'd7, 32'd10, 16'd1});
      chk({tag, "_e2"}, {m_log[2], v_log[2], r_log[2]}, {32'd9, 32'd30, 16'd1});
      chk({tag, "_t0"}, w_cyc[0], base + 4);
      chk({tag, "_t1"}, w_cyc[1], base + 8);
      chk({tag, "_t2"}, w_cyc[2], base + 12);
    end
    chk({tag, "_ndone"}, d_cyc.size(), 1);
    if (d_cyc.size() == 1) chk({tag, "_tdone"}, d_cyc[0], base + 13);
  endtask

  initial begin
    m_val[0] = 32'd5; m_row[0] = 16'd0; m_col[0] = 16'd2;
    m_val[1] = 32'd7; m_row[1] = 16'd1; m_col[1] = 16'd0;
    m_val[2] = 32'd9; m_row[2] = 16'd1; m_col[2] = 16'd2;
    m_vec[0] = 32'd10; m_vec[1] = 32'd20; m_vec[2] = 32'd30;

    // Reset state
    tick();
    tick();
    chk_idle_outputs("reset");
`ifdef FEEDER_STALL_CNT_EN
    chk("reset_stall_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Basic nnz=3 pass with exact write and done timing
    clear_logs();
    go(16'd3);
    chk("p1_busy", busy, 1);
    chk("p1_ent_rd", {ent_rd_en, ent_addr}, {1'b1, 16'd0});
    tick();
    chk("p1_vec_rd", {vec_rd_en, vec_addr}, {1'b1, 16'd2});
    repeat (15) tick();
    chk_three("p1", s0);
    chk("p1_busy_cycles", n_busy, 12);
    chk("p1_nrd", n_rd, 3);

    // nnz=0: done next cycle, no RAM/FIFO activity, never busy
    clear_logs();
    go(16'd0);
    chk("z_done", {done, busy}, {1'b1, 1'b0});
    tick();
    chk("z_done_end", done, 0);
    repeat (3) tick();
    chk("z_nrd", n_rd, 0);
    chk("z_nwr", m_log.size(), 0);
    chk("z_busy", n_busy, 0);
    chk("z_ndone", d_cyc.size(), 1);
    if (d_cyc.size() == 1) chk("z_tdone", d_cyc[0], s0 + 1);

    // nnz=2 with vec FIFO full for 5 cycles at the first PUSH
    clear_logs();
    go(16'd2);
    repeat (3) tick();
    vec_val_full = 1'b1;
    repeat (5) begin
      #1;
      chk("st_no_wr", {matrix_val_wr_en, vec_val_wr_en, row_id_wr_en}, 0);
      chk("st_hold", {matrix_val_din, vec_val_din, row_id_din}, {32'd5, 32'd30, 16'd0});
      tick();
    end
    vec_val_full = 1'b0;
    repeat (10) tick();
    chk("st_nw", m_log.size(), 2);
    if (m_log.size() == 2 && v_log.size() == 2 && r_log.size() == 2) begin
      chk("st_e0", {m_log[0], v_log[0], r_log[0]}, {32'd5, 32'd30, 16'd0});
      chk("st_e1", {m_log[1], v_log[1], r_log[1]}, {32'd7, 32'd10, 16'd1});
      chk("st_t0", w_cyc[0], s0 + 9);
      chk("st_t1", w_cyc[1], s0 + 13);
    end
    chk("st_ndone", d_cyc.size(), 1);
    if (d_cyc.size() == 1) chk("st_tdone", d_cyc[0], s0 + 14);
`ifdef FEEDER_STALL_CNT_EN
    chk("st_stall_cnt", stall_cnt, 5);
`endif

    // start re-pulsed mid-pass is ignored
    clear_logs();
    go(16'd3);
    tick();
    start = 1'b1;
    nnz   = 16'd1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk_three("rp", s0);

    // Asynchronous reset in WAIT_VEC of entry 1, then a fresh nnz=1 pass
    clear_logs();
    go(16'd3);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk_idle_outputs("arst");
    chk("arst_nw", m_log.size(), 1);
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
    go(16'd1);
    repeat (8) tick();
    chk("ar1_nw", m_log.size(), 1);
    if (m_log.size() == 1 && v_log.size() == 1 && r_log.size() == 1) begin
      chk("ar1_e0", {m_log[0], v_log[0], r_log[0]}, {32'd5, 32'd30, 16'd0});
      chk("ar1_t0", w_cyc[0], s0 + 4);
    end
    chk("ar1_ndone", d_cyc.size(), 1);
    if (d_cyc.size() == 1) chk("ar1_tdone", d_cyc[0], s0 + 5);

    // nnz=16 with randomly toggling full flags
    for (int i = 0; i < 32; i++) m_vec[i] = $urandom;
    for (int i = 0; i < 16; i++) begin
      m_val[i] = $urandom;
      m_row[i] = 16'($urandom_range(0, 65535));
      m_col[i] = 16'($urandom_range(0, 31));
    end
    clear_logs();
    go(16'd16);
    for (int c = 0; c < 600; c++) begin
      matrix_val_full = ($urandom_range(0, 3) == 0);
      vec_val_full    = ($urandom_range(0, 3) == 0);
      row_id_full     = ($urandom_range(0, 3) == 0);
      #1;
      if (matrix_val_full || vec_val_full || row_id_full)
        chk("rnd_no_wr_full", {matrix_val_wr_en, vec_val_wr_en, row_id_wr_en}, 0);
      chk("rnd_cnt_v", v_log.size(), m_log.size());
      chk("rnd_cnt_r", r_log.size(), m_log.size());
      tick();
      if (d_cyc.size() != 0) break;
    end
    matrix_val_full = 1'b0;
    vec_val_full    = 1'b0;
    row_id_full     = 1'b0;
    chk("rnd_done_seen", d_cyc.size(), 1);
    chk("rnd_nw", {m_log.size(), v_log.size(), r_log.size()}, {32'd16, 32'd16, 32'd16});
    if (m_log.size() == 16 && v_log.size() == 16 && r_log.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("rnd_e%0d", i), {m_log[i], v_log[i], r_log[i]},
            {m_val[i], m_vec[m_col[i]], m_row[i]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
